adder_control_unit: RTL and testbench



---
 rtl/adder_ctrl_pkg.sv | 25 ++
 rtl/adder_control_unit.sv | 100 ++++++++++
 tb/tb_adder_control_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the cumulative-adder controller.
// Register-file addressing and FSM state encoding.
package adder_ctrl_pkg;

  localparam int RF_ADDR_W = 3;

  localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = '0;

  localparam logic [RF_ADDR_W-1:0] DEF_REG_I   = 3'd1;
  localparam logic [RF_ADDR_W-1:0] DEF_REG_SUM = 3'd2;
  localparam logic [RF_ADDR_W-1:0] DEF_REG_ONE = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT_I   = 4'd1,
    S_INIT_SUM = 4'd2,
    S_INIT_ONE = 4'd3,
    S_CMP      = 4'd4,
    S_ADD      = 4'd5,
    S_INC      = 4'd6,
    S_OUT      = 4'd7,
    S_DONE     = 4'd8
  } state_e;

endpackage

// File: rtl/adder_control_unit.sv
// Moore controller sequencing the 1+2+...+10 cumulative-adder datapath.
// All outputs decode from the current state only.
module adder_control_unit
  import adder_ctrl_pkg::*;
#(
  parameter logic [RF_ADDR_W-1:0] REG_I   = DEF_REG_I,
  parameter logic [RF_ADDR_W-1:0] REG_SUM = DEF_REG_SUM,
  parameter logic [RF_ADDR_W-1:0] REG_ONE = DEF_REG_ONE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 iLe10,
  output logic                 RFSrcMuxSel,
  output logic [RF_ADDR_W-1:0] readAddr1,
  output logic [RF_ADDR_W-1:0] readAddr2,
  output logic [RF_ADDR_W-1:0] writeAddr,
  output logic                 writeEn,
  output logic                 outBuf,
  output logic                 busy,
  output logic                 done
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = S_IDLE;
    RFSrcMuxSel = 1'b0;
    readAddr1   = RF_ZERO_ADDR;
    readAddr2   = RF_ZERO_ADDR;
    writeAddr   = RF_ZERO_ADDR;
    writeEn     = 1'b0;
    outBuf      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy    = 1'b0;
        state_d = start ? S_INIT_I : S_IDLE;
      end
      S_INIT_I: begin
        RFSrcMuxSel = 1'b1;
        writeAddr   = REG_I;
        writeEn     = 1'b1;
        state_d     = S_INIT_SUM;
      end
      S_INIT_SUM: begin
        writeAddr = REG_SUM;
        writeEn   = 1'b1;
        state_d   = S_INIT_ONE;
      end
      S_INIT_ONE: begin
        RFSrcMuxSel = 1'b1;
        writeAddr   = REG_ONE;
        writeEn     = 1'b1;
        state_d     = S_CMP;
      end
      S_CMP: begin
        readAddr1 = REG_I;
        state_d   = iLe10 ? S_ADD : S_OUT;
      end
      S_ADD: begin
        readAddr1 = REG_I;
        readAddr2 = REG_SUM;
        writeAddr = REG_SUM;
        writeEn   = 1'b1;
        state_d   = S_INC;
      end
      S_INC: begin
        readAddr1 = REG_I;
        readAddr2 = REG_ONE;
        writeAddr = REG_I;
        writeEn   = 1'b1;
        state_d   = S_CMP;
      end
      S_OUT: begin
        readAddr1 = REG_SUM;
        outBuf    = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        readAddr1 = REG_SUM;
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      // illegal encodings look idle and fall back to S_IDLE
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adder_control_unit.sv
// Directed bench for adder_control_unit driving a behavioural
// cumulative-adder datapath (register file, mux, adder, comparator).
module tb_adder_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       iLe10;
  logic       RFSrcMuxSel;
  logic [2:0] readAddr1;
  logic [2:0] readAddr2;
  logic [2:0] writeAddr;
  logic       writeEn;
  logic       outBuf;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0] rf [8];
  logic [7:0] rData1, rData2, wData, outPort;
  logic       stub = 1'b0;

  always #5 clk = ~clk;

  adder_control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .iLe10       (iLe10),
    .RFSrcMuxSel (RFSrcMuxSel),
    .readAddr1   (readAddr1),
    .readAddr2   (readAddr2),
    .writeAddr   (writeAddr),
    .writeEn     (writeEn),
    .outBuf      (outBuf),
    .busy        (busy),
    .done        (done)
  );

  assign rData1 = (readAddr1 == 3'd0) ? 8'd0 : rf[readAddr1];
  assign rData2 = (readAddr2 == 3'd0) ? 8'd0 : rf[readAddr2];
  assign wData  = RFSrcMuxSel ? 8'd1 : (rData1 + rData2);
  assign iLe10  = stub ? 1'b0 : (rData1 <= 8'd10);

  initial begin
    for (int k = 0; k < 8; k++) rf[k] = 8'd0;
    outPort = 8'd0;
  end

  always @(posedge clk) begin
    if (writeEn && writeAddr != 3'd0) rf[writeAddr] <= wData;
    if (outBuf) outPort <= rData1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observes cycles 1..lim of a run; start pulses high in cycles p1/p2/p3.
  task automatic run_obs(input int lim, input int p1, input int p2,
                         input int p3, output int dc, output int nd,
                         output int we, output int ob,
                         output logic [7:0] ov, output int idle_c);
    dc = 0; nd = 0; we = 0; ob = 0; ov = 8'd0; idle_c = 0;
    for (int c = 1; c <= lim; c++) begin
      start = (c == p1 || c == p2 || c == p3);
      #1;
      if (writeEn) we++;
      if (outBuf) ob++;
      if (done) begin
        nd++;
        if (dc == 0) begin dc = c; ov = outPort; end
      end
      if (!busy && idle_c == 0) idle_c = c;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if ({busy, done, writeEn, outBuf, RFSrcMuxSel} !== 5'b0 ||
          {readAddr1, readAddr2, writeAddr} !== 9'b0) begin
        errors++;
        $display("FAIL reset_outputs: got busy=%b done=%b we=%b ob=%b, want all 0",
                 busy, done, writeEn, outBuf);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || writeEn !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: cyc %0d busy=%b we=%b done=%b, want 0",
                 c, busy, writeEn, done);
      end
    end
  endtask

  task automatic test_nominal();
    int dc, nd, we, ob, idle_c;
    logic [7:0] ov;
    launch();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: got %b want 1", busy);
    end
    run_obs(40, 0, 0, 0, dc, nd, we, ob, ov, idle_c);
    checks++;
    if (dc !== 36) begin
      errors++;
      $display("FAIL nominal_done_cycle: got %0d want 36", dc);
    end
    checks++;
    if (ov !== 8'd55) begin
      errors++;
      $display("FAIL nominal_outport: got %0d want 55", ov);
    end
    checks++;
    if (we !== 23 || ob !== 1) begin
      errors++;
      $display("FAIL nominal_pulses: got we=%0d ob=%0d want 23/1", we, ob);
    end
    checks++;
    if (idle_c !== 37 || nd !== 1) begin
      errors++;
      $display("FAIL nominal_idle: got idle=%0d ndone=%0d want 37/1",
               idle_c, nd);
    end
  endtask

  task automatic test_back_to_back();
    int dcs[$];
    int lows;
    lows = 0;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 112; c++) begin
      if (done) begin
        dcs.push_back(c);
        checks++;
        if (outPort !== 8'd55) begin
          errors++;
          $display("FAIL b2b_outport: cyc %0d got %0d want 55", c, outPort);
        end
      end
      if (!busy) lows++;
      tick();
    end
    start = 1'b0;
    checks++;
    if (dcs.size() != 3 || dcs[0] != 36 || dcs[1] != 73 || dcs[2] != 110) begin
      errors++;
      $display("FAIL b2b_done_cycles: got n=%0d first=%0d want 36,73,110",
               dcs.size(), (dcs.size() > 0) ? dcs[0] : -1);
    end
    checks++;
    if (lows !== 3) begin
      errors++;
      $display("FAIL b2b_idle_cycles: got %0d want 3 (cyc 37,74,111)", lows);
    end
    repeat (45) tick();
  endtask

  task automatic test_start_busy();
    int dc, nd, we, ob, idle_c;
    logic [7:0] ov;
    launch();
    run_obs(60, 5, 20, 35, dc, nd, we, ob, ov, idle_c);
    checks++;
    if (dc !== 36 || nd !== 1 || ov !== 8'd55) begin
      errors++;
      $display("FAIL start_busy: got done=%0d n=%0d out=%0d want 36/1/55",
               dc, nd, ov);
    end
    checks++;
    if (we !== 23 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_busy_norun: got we=%0d busy=%b want 23/0", we, busy);
    end
  endtask

  task automatic test_reset_mid();
    int dc, nd, we, ob, idle_c;
    logic [7:0] ov;
    launch();
    repeat (14) tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, writeEn, outBuf} !== 4'b0 || readAddr1 !== 3'd0) begin
      errors++;
      $display("FAIL reset_async: got busy=%b we=%b ra1=%0d want 0",
               busy, writeEn, readAddr1);
    end
    repeat (2) tick();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle: got busy=%b done=%b want 0", busy, done);
      end
    end
    launch();
    run_obs(40, 0, 0, 0, dc, nd, we, ob, ov, idle_c);
    checks++;
    if (dc !== 36 || ov !== 8'd55) begin
      errors++;
      $display("FAIL reset_mid_rerun: got done=%0d out=%0d want 36/55", dc, ov);
    end
  endtask

  task automatic test_stub();
    int we, dc;
    logic saw_cmp, saw_out;
    we = 0; dc = 0; saw_cmp = 1'b0; saw_out = 1'b0;
    stub = 1'b1;
    launch();
    for (int c = 1; c <= 10; c++) begin
      if (writeEn) we++;
      if (c == 4 && readAddr1 == 3'd1 && !writeEn && !outBuf) saw_cmp = 1'b1;
      if (c == 5 && outBuf) saw_out = 1'b1;
      if (done && dc == 0) dc = c;
      tick();
    end
    stub = 1'b0;
    checks++;
    if (dc !== 6 || we !== 3) begin
      errors++;
      $display("FAIL stub_run: got done=%0d we=%0d want 6/3", dc, we);
    end
    checks++;
    if (!saw_cmp || !saw_out) begin
      errors++;
      $display("FAIL stub_seq: got cmp4=%b out5=%b want 1/1", saw_cmp, saw_out);
    end
    checks++;
    if (rf[2] !== 8'd0 || outPort !== 8'd0) begin
      errors++;
      $display("FAIL stub_sum: got sum=%0d out=%0d want 0/0", rf[2], outPort);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    test_stub();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
